// File: rtl/ysyx_23060208_axi_sram_slave_pkg.sv
// ysyx_23060208_axi_sram_slave_pkg: shared bus constants, response codes and FSM encodings
package ysyx_23060208_axi_sram_slave_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
  // byte i of data lands on lane off+i; lanes past the word end are dropped
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb, input logic [1:0] off);
    logic [31:0] sd;
    logic [3:0] sm;
    sd = data << {off, 3'b000};
    sm = strb << off;
    merge_bytes = old;
    for (int i = 0; i < 4; i++) if (sm[i]) merge_bytes[8*i +: 8] = sd[8*i +: 8];
  endfunction
endpackage

// File: rtl/ysyx_23060208_axi_sram_slave_if.sv
// ysyx_23060208_axi_sram_slave_if: single-beat AXI bus between a master and the SRAM slave
interface ysyx_23060208_axi_sram_slave_if;
  import ysyx_23060208_axi_sram_slave_pkg::*;
  logic awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic bvalid, bready;
  logic [1:0] bresp;
  logic [ID_W-1:0] bid;
  logic arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0] arid;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic [ID_W-1:0] rid;
  modport master(output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
                 bready, arvalid, araddr, arid, arlen, arsize, arburst, rready,
                 input awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid);
  modport slave(input awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
                bready, arvalid, araddr, arid, arlen, arsize, arburst, rready,
                output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid);
endinterface

// File: rtl/ysyx_23060208_lfsr16.sv
// ysyx_23060208_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11)
module ysyx_23060208_lfsr16
  import ysyx_23060208_axi_sram_slave_pkg::*;
#(parameter logic [15:0] SEED = LFSR_SEED) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);
  always_ff @(posedge clock) q <= reset ? SEED : {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/ysyx_23060208_axi_sram_slave.sv
// ysyx_23060208_axi_sram_slave: single-beat AXI SRAM slave with independent read/write FSMs
module ysyx_23060208_axi_sram_slave
  import ysyx_23060208_axi_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT = 1,
  parameter int WRITE_LAT = 1,
  parameter int RAND_EN = 0
) (
  input logic clock,
  input logic reset,
  ysyx_23060208_axi_sram_slave_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic [15:0] lfsr, r_cnt, w_cnt, r_delay, w_delay;
  logic [1:0] jitter, w_resp;
  logic [31:0] ar_addr, aw_addr, rs_addr, r_off, w_off, r_word;
  logic [7:0] ar_len, aw_len, rs_len;
  logic [3:0] ar_id, aw_id, rs_id;
  logic r_in, w_in, ar_hs, aw_hs, w_hs, r_load, b_load, unused;
  ysyx_23060208_lfsr16 u_lfsr (.clock(clock), .reset(reset), .q(lfsr));
  assign unused = ^{bus.awsize, bus.arsize, bus.awburst, bus.arburst, bus.wlast,
                    bus.wdata[63:32], bus.wstrb[7:4], lfsr};
  assign jitter = RAND_EN != 0 ? lfsr[1:0] : 2'd0;
  assign r_delay = 16'(READ_LAT - 1) + 16'(jitter);
  assign w_delay = 16'(WRITE_LAT - 1) + 16'(jitter);
  // a zero-delay read loads straight from the AR channel in the handshake cycle
  assign rs_addr = r_state == R_IDLE ? bus.araddr : ar_addr;
  assign rs_len = r_state == R_IDLE ? bus.arlen : ar_len;
  assign rs_id = r_state == R_IDLE ? bus.arid : ar_id;
  assign r_off = rs_addr - BASE_ADDR;
  assign r_in = r_off < SPAN;
  assign r_word = mem[r_off[AW+1:2]] >> {r_off[1:0], 3'b000};
  assign w_off = aw_addr - BASE_ADDR;
  assign w_in = w_off < SPAN;
  assign w_resp = !w_in ? RESP_DECERR : aw_len != 8'd0 ? RESP_SLVERR : RESP_OKAY;
  always_comb begin
    bus.arready = r_state == R_IDLE;
    bus.rvalid = r_state == R_RESP;
    bus.rlast = r_state == R_RESP;
    bus.awready = w_state == W_IDLE;
    bus.wready = w_state == W_DATA;
    bus.bvalid = w_state == W_RESP;
    ar_hs = bus.arready && bus.arvalid;
    aw_hs = bus.awready && bus.awvalid;
    w_hs = bus.wready && bus.wvalid;
    r_load = (ar_hs && r_delay == 16'd0) || (r_state == R_WAIT && r_cnt == 16'd0);
    b_load = (w_hs && w_delay == 16'd0) || (w_state == W_WAIT && w_cnt == 16'd0);
    r_next = r_load ? R_RESP : ar_hs ? R_WAIT : (bus.rvalid && bus.rready) ? R_IDLE : r_state;
    w_next = b_load ? W_RESP : aw_hs ? W_DATA : w_hs ? W_WAIT
           : (bus.bvalid && bus.bready) ? W_IDLE : w_state;
  end
  always_ff @(posedge clock) begin
    r_state <= reset ? R_IDLE : r_next;
    w_state <= reset ? W_IDLE : w_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      {ar_addr, ar_id, ar_len, r_cnt} <= '0;
      {aw_addr, aw_id, aw_len, w_cnt} <= '0;
      bus.rdata <= '0;
      bus.rresp <= RESP_OKAY;
      bus.rid <= '0;
      bus.bresp <= RESP_OKAY;
      bus.bid <= '0;
    end else begin
      if (ar_hs) {ar_addr, ar_id, ar_len} <= {bus.araddr, bus.arid, bus.arlen};
      r_cnt <= ar_hs ? r_delay - 16'd1 : r_cnt - 16'(r_state == R_WAIT);
      if (r_load) begin
        bus.rdata <= r_in ? {32'd0, r_word} : '0;
        bus.rresp <= !r_in ? RESP_DECERR : rs_len != 8'd0 ? RESP_SLVERR : RESP_OKAY;
        bus.rid <= rs_id;
      end
      if (aw_hs) {aw_addr, aw_id, aw_len} <= {bus.awaddr, bus.awid, bus.awlen};
      w_cnt <= w_hs ? w_delay - 16'd1 : w_cnt - 16'(w_state == W_WAIT);
      if (b_load) begin
        bus.bresp <= w_resp;
        bus.bid <= aw_id;
      end
    end
  end
  // storage is never reset; a same-cycle read sees the pre-write word
  always_ff @(posedge clock)
    if (!reset && w_hs && w_resp == RESP_OKAY)
      mem[w_off[AW+1:2]] <= merge_bytes(mem[w_off[AW+1:2]], bus.wdata[31:0], bus.wstrb[3:0], w_off[1:0]);
endmodule

// File: tb/tb_ysyx_23060208_axi_sram_slave.sv
// tb_ysyx_23060208_axi_sram_slave: directed checks on a fixed-latency slave, random checks on a jittered one
module tb_ysyx_23060208_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int LIM = 50;
  logic clock = 0, reset = 0, sel = 0;
  logic m_awvalid = 0, m_wvalid = 0, m_wlast = 1, m_bready = 0, m_arvalid = 0, m_rready = 0;
  logic [31:0] m_awaddr = 0, m_araddr = 0;
  logic [3:0] m_awid = 0, m_arid = 0;
  logic [7:0] m_awlen = 0, m_arlen = 0, m_wstrb = 0;
  logic [2:0] m_awsize = 3'd2, m_arsize = 3'd2;
  logic [1:0] m_awburst = 2'd1, m_arburst = 2'd1;
  logic [63:0] m_wdata = 0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [1:0] s_bresp, s_rresp;
  logic [3:0] s_bid, s_rid;
  logic [63:0] s_rdata;
  int compared = 0, mismatched = 0;
  logic [7:0] ref_mem [logic [31:0]];
  ysyx_23060208_axi_sram_slave_if b0 ();
  ysyx_23060208_axi_sram_slave_if b1 ();
  ysyx_23060208_axi_sram_slave dut0 (.clock(clock), .reset(reset), .bus(b0));
  ysyx_23060208_axi_sram_slave #(.RAND_EN(1)) dut1 (.clock(clock), .reset(reset), .bus(b1));
  always #5 clock = ~clock;
  assign {b0.awvalid, b0.wvalid, b0.bready, b0.arvalid, b0.rready} =
         {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} & {5{~sel}};
  assign {b1.awvalid, b1.wvalid, b1.bready, b1.arvalid, b1.rready} =
         {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} & {5{sel}};
  assign {b0.awaddr, b0.awid, b0.awlen, b0.awsize, b0.awburst} = {m_awaddr, m_awid, m_awlen, m_awsize, m_awburst};
  assign {b1.awaddr, b1.awid, b1.awlen, b1.awsize, b1.awburst} = {m_awaddr, m_awid, m_awlen, m_awsize, m_awburst};
  assign {b0.wdata, b0.wstrb, b0.wlast} = {m_wdata, m_wstrb, m_wlast};
  assign {b1.wdata, b1.wstrb, b1.wlast} = {m_wdata, m_wstrb, m_wlast};
  assign {b0.araddr, b0.arid, b0.arlen, b0.arsize, b0.arburst} = {m_araddr, m_arid, m_arlen, m_arsize, m_arburst};
  assign {b1.araddr, b1.arid, b1.arlen, b1.arsize, b1.arburst} = {m_araddr, m_arid, m_arlen, m_arsize, m_arburst};
  assign {s_awready, s_wready, s_bvalid, s_bresp, s_bid, s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid} = sel
    ? {b1.awready, b1.wready, b1.bvalid, b1.bresp, b1.bid, b1.arready, b1.rvalid, b1.rdata, b1.rresp, b1.rlast, b1.rid}
    : {b0.awready, b0.wready, b0.bvalid, b0.bresp, b0.bid, b0.arready, b0.rvalid, b0.rdata, b0.rresp, b0.rlast, b0.rid};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'h1000;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a, input logic [7:0] len);
    return !in_range(a) ? 2'b11 : len != 0 ? 2'b10 : 2'b00;
  endfunction

  // byte-addressed reference memory
  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i] && int'(a[1:0]) + i < 4) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4 - int'(a[1:0]); i++)
      r[8*i +: 8] = ref_mem.exists(a + 32'(i)) ? ref_mem[a + 32'(i)] : 8'hxx;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [3:0] bid, output int lat);
    int n;
    @(negedge clock);
    m_awvalid = 1; m_awaddr = a; m_awid = id; m_awlen = len;
    n = 0;
    while (!s_awready && n < LIM) begin @(negedge clock); n++; end
    chk("aw_wait", 64'(n < LIM), 1);
    @(posedge clock); #1;
    m_awvalid = 0; m_wvalid = 1; m_wdata = {$urandom, d}; m_wstrb = {4'hF, s};
    @(negedge clock);
    n = 0;
    while (!s_wready && n < LIM) begin @(negedge clock); n++; end
    chk("w_wait", 64'(n < LIM), 1);
    @(posedge clock); #1;
    m_wvalid = 0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!s_bvalid && lat < LIM);
    resp = s_bresp; bid = s_bid;
    m_bready = 1;
    @(posedge clock); #1;
    m_bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input bit hold,
                         output logic [63:0] d, output logic [1:0] resp, output logic [3:0] rid,
                         output logic last, output int lat);
    int n;
    @(negedge clock);
    m_arvalid = 1; m_araddr = a; m_arid = id; m_arlen = len;
    n = 0;
    while (!s_arready && n < LIM) begin @(negedge clock); n++; end
    chk("ar_wait", 64'(n < LIM), 1);
    @(posedge clock); #1;
    m_arvalid = 0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!s_rvalid && lat < LIM);
    d = s_rdata; resp = s_rresp; rid = s_rid; last = s_rlast;
    if (!hold) begin
      m_rready = 1;
      @(posedge clock); #1;
      m_rready = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic [1:0] resp;
    logic [3:0] id, rid;
    logic [31:0] a, d;
    logic [31:0] pool [8];
    logic [7:0] len;
    logic [3:0] s;
    logic last;
    int lat, kind;
    do_reset();
    @(negedge clock);
    chk("rst_arready", s_arready, 1);
    chk("rst_awready", s_awready, 1);
    chk("rst_wready", s_wready, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_ids", {s_rid, s_bid, s_rresp, s_bresp}, 0);
    do_write(32'h8000_0010, 4'd3, 0, 32'hDEAD_BEEF, 4'hF, resp, rid, lat);
    chk("w1_bresp", resp, 0); chk("w1_bid", rid, 3); chk("w1_lat", lat, 1);
    do_read(32'h8000_0012, 4'd5, 0, 0, rd, resp, rid, last, lat);
    chk("r1_rdata", rd, 64'hDEAD); chk("r1_rresp", resp, 0);
    chk("r1_rid", rid, 5); chk("r1_rlast", last, 1); chk("r1_lat", lat, 1);
    do_write(32'h8000_0013, 4'd1, 0, 32'h0000_00AA, 4'h1, resp, rid, lat);
    chk("w2_bresp", resp, 0);
    do_read(32'h8000_0010, 4'd2, 0, 0, rd, resp, rid, last, lat);
    chk("r2_rdata", rd, 64'hAAAD_BEEF);
    do_read(32'h0000_0000, 4'd4, 0, 0, rd, resp, rid, last, lat);
    chk("oor_rresp", resp, 2'b11); chk("oor_rdata", rd, 0);
    do_write(32'h9000_0000, 4'd6, 0, 32'h1234_5678, 4'hF, resp, rid, lat);
    chk("oor_bresp", resp, 2'b11);
    do_write(32'h8000_0010, 4'd2, 8'd3, 32'h1111_1111, 4'hF, resp, rid, lat);
    chk("burst_bresp", resp, 2'b10);
    do_read(32'h8000_0010, 4'd2, 8'd1, 0, rd, resp, rid, last, lat);
    chk("burst_rresp", resp, 2'b10); chk("burst_rdata", rd, 64'hAAAD_BEEF);
    // stalled read response while a write runs to completion
    do_read(32'h8000_0010, 4'd7, 0, 1, rd, resp, rid, last, lat);
    chk("hold_rdata0", rd, 64'hAAAD_BEEF);
    repeat (2) begin
      @(negedge clock);
      chk("hold_rvalid", s_rvalid, 1); chk("hold_rdata", s_rdata, 64'hAAAD_BEEF); chk("hold_arready", s_arready, 0);
    end
    do_write(32'h8000_0020, 4'd9, 0, 32'h1234_5678, 4'hF, resp, id, lat);
    chk("hold_bresp", resp, 0); chk("hold_bid", id, 9); chk("hold_wlat", lat, 1);
    repeat (2) begin
      @(negedge clock);
      chk("hold_rvalid2", s_rvalid, 1); chk("hold_rdata2", s_rdata, 64'hAAAD_BEEF);
      chk("hold_rid2", s_rid, 7); chk("hold_arready2", s_arready, 0);
    end
    m_rready = 1;
    @(posedge clock); #1;
    m_rready = 0;
    @(negedge clock);
    chk("hold_release", {s_rvalid, s_arready}, 2'b01);
    do_read(32'h8000_0020, 4'd1, 0, 0, rd, resp, rid, last, lat);
    chk("hold_wdata", rd, 64'h1234_5678);
    // reset between AW and W abandons the write
    @(negedge clock);
    m_awvalid = 1; m_awaddr = 32'h8000_0010; m_awid = 1; m_awlen = 0;
    @(posedge clock); #1;
    m_awvalid = 0; reset = 1;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    chk("mid_awready", s_awready, 1); chk("mid_wready", s_wready, 0);
    m_wvalid = 1; m_wdata = 0; m_wstrb = 8'hFF;
    @(negedge clock);
    chk("mid_bvalid", s_bvalid, 0);
    m_wvalid = 0;
    do_read(32'h8000_0010, 4'd1, 0, 0, rd, resp, rid, last, lat);
    chk("mid_keep", rd, 64'hAAAD_BEEF);
    // jittered slave against the byte-level reference model
    sel = 1;
    ref_mem.delete();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      pool[k] = BASE + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      d = $urandom;
      do_write(pool[k], 4'(k), 0, d, 4'hF, resp, rid, lat);
      ref_write(pool[k], d, 4'hF);
      chk("init_bresp", resp, 0);
    end
    for (int t = 0; t < 100; t++) begin
      kind = $urandom_range(0, 7);
      a = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
      if (kind == 0) a = ($urandom_range(0, 1) ? 32'h0000_1000 : BASE + 32'h1000) + 32'($urandom_range(0, 255));
      len = kind == 1 ? 8'($urandom_range(1, 255)) : 8'd0;
      id = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        do_write(a, id, len, d, s, resp, rid, lat);
        if (resp_of(a, len) == 2'b00) ref_write(a, d, s);
        chk("rnd_bresp", resp, resp_of(a, len)); chk("rnd_bid", rid, id);
        chk("rnd_wlat", 64'(lat >= 1 && lat <= 4), 1);
      end else begin
        do_read(a, id, len, 0, rd, resp, rid, last, lat);
        chk("rnd_rresp", resp, resp_of(a, len)); chk("rnd_rid", rid, id);
        chk("rnd_rdata", rd, in_range(a) ? {32'd0, ref_read(a)} : 64'd0);
        chk("rnd_rlat", 64'(lat >= 1 && lat <= 4), 1);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ysyx_23060208_axi_sram_slave.md
YSYX_23060208_AXI_SRAM_SLAVE -- requirements
Module: ysyx_23060208_axi_sram_slave

Interface
REQ-001 Parameter BASE_ADDR, 32'h8000_0000, byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, 1024, number of 32-bit storage words (power of two).
REQ-003 Parameter READ_LAT, 1, minimum cycles from AR handshake to rvalid (>=1).
REQ-004 Parameter WRITE_LAT, 1, minimum cycles from W handshake to bvalid (>=1).
REQ-005 Parameter RAND_EN, 0, nonzero adds 0-3 LFSR jitter cycles per transaction.
REQ-006 clock  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 AW channel: awvalid in 1, awready out 1, awaddr in 32, awid in 4, awlen in 8, awsize in 3, awburst in 2.
REQ-009 W channel: wvalid in 1, wready out 1, wdata in 64, wstrb in 8, wlast in 1.
REQ-010 B channel: bvalid out 1, bready in 1, bresp out 2, bid out 4.
REQ-011 AR channel: arvalid in 1, arready out 1, araddr in 32, arid in 4, arlen in 8, arsize in 3, arburst in 2.
REQ-012 R channel: rvalid out 1, rready in 1, rdata out 64, rresp out 2, rlast out 1, rid out 4.

Function
REQ-013 The read and write paths SHALL be independent FSMs and may be active in the same cycle.
REQ-014 Read FSM states SHALL be R_IDLE, R_WAIT, R_RESP; arready = (state == R_IDLE).
REQ-015 An AR handshake SHALL capture araddr, arid, arlen, arsize and move R_IDLE -> R_WAIT with delay counter = READ_LAT-1 (+ jitter).
REQ-016 R_WAIT SHALL decrement the counter and, at zero, load rdata/rresp/rid and move to R_RESP; READ_LAT=1 gives rvalid in the cycle after the AR handshake.
REQ-017 In R_RESP rvalid and rlast SHALL be 1 and all R outputs SHALL hold stable until rvalid && rready, then return to R_IDLE.
REQ-018 Read data SHALL be right-aligned: rdata[31:0] = stored word >> (8*araddr[1:0]), upper bits zero-filled; rdata[63:32] = 0.
REQ-019 Write FSM states SHALL be W_IDLE, W_DATA, W_WAIT, W_RESP; awready = (state == W_IDLE); wready = (state == W_DATA).
REQ-020 AW handshake SHALL capture awaddr, awid, awlen and move to W_DATA; W data is never accepted before AW.
REQ-021 W handshake SHALL commit the write in that cycle: byte i (i=0..3) of wdata[31:0] is written to byte address awaddr+i when wstrb[i]=1 and the target lies in the addressed word; wstrb[7:4] ignored.
REQ-022 W_WAIT SHALL count WRITE_LAT-1 (+ jitter) cycles, then present bvalid with bid = captured awid in W_RESP, held until bready, then W_IDLE.
REQ-023 Address out of [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL give resp 2'b11, rdata 0, no storage update.
REQ-024 awlen or arlen != 0 SHALL give resp 2'b10 (single beat still completed, no write); otherwise resp 2'b00. awsize/arsize/burst SHALL not affect behaviour.
REQ-025 Read and write to the same word completing in the same cycle: the read SHALL return pre-write data.
REQ-026 Jitter SHALL come from a 16-bit LFSR (taps 16,14,13,11) stepped every cycle, seed 16'hACE1, using bits [1:0].

Reset
REQ-027 Reset SHALL force R_IDLE, W_IDLE, all valid outputs 0, arready/awready 1 after reset release, wready 0, rdata/rresp/rid/bresp/bid 0, counters 0, LFSR to seed.
REQ-028 Reset mid-transaction SHALL abandon it; storage contents SHALL not be cleared, and an uncommitted write SHALL not occur.

Structure
REQ-029 Response codes (OKAY, SLVERR, DECERR) and FSM state encodings SHALL live in the shared package/header with the other bus constants.
REQ-030 The LFSR SHALL be a separate sub-module ysyx_23060208_lfsr16; storage is an inferred register array inside this module.

Verification
REQ-031 Reset, write 32'hDEADBEEF to 0x8000_0010 with wstrb 4'hF, awid 3, READ_LAT/WRITE_LAT=1 -> bvalid one cycle after W handshake, bresp 00, bid 3.
REQ-032 Read 0x8000_0012, arid 5 -> rvalid the cycle after AR handshake, rdata 64'h0000_0000_0000_DEAD, rresp 00, rid 5, rlast 1.
REQ-033 Write wdata 32'h0000_00AA, wstrb 4'h1 to 0x8000_0013, then read 0x8000_0010 -> rdata 32'hAAADBEEF.
REQ-034 Read 0x0000_0000 and write 0x9000_0000 -> rresp/bresp 11, rdata 0, memory unchanged.
REQ-035 Hold rready low 5 cycles in R_RESP while issuing a write -> R outputs stable, write completes independently, arready stays 0.
REQ-036 RAND_EN=1, 100 random single-beat reads/writes vs. reference model -> all data match, every latency within [LAT, LAT+3].
